// File: rtl/inst_axi_reader.sv
// Instruction-fetch AXI4 read master: single-beat uncached fetches or
// critical-word-first WRAP line refills for the I-cache. Stalls the PC stage while busy.
module inst_axi_reader #(
  parameter int          LINE_WORDS = 4,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     fetch_req_i,
  input  logic [31:0]              fetch_addr_i,
  input  logic                     fetch_cached_i,
  input  logic                     flush_i,
  output logic                     stall_req_o,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_rdata_o,
  output logic                     bus_error_o,
  output logic                     refill_valid_o,
  output logic [31:0]              refill_addr_o,
  output logic [32*LINE_WORDS-1:0] refill_data_o,
  output logic [3:0]               arid_o,
  output logic [31:0]              araddr_o,
  output logic [7:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  input  logic [3:0]               rid_i,
  input  logic [31:0]              rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rlast_i,
  input  logic                     rvalid_i,
  output logic                     rready_o
);

  localparam int IDXW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             addr_q;
  logic                    cached_q;
  logic                    cancel_q;
  logic                    err_q;
  logic [7:0]              beat_q;
  logic [31:0]             inst_q;
  logic [31:0]             refill_addr_q;
  logic [32*LINE_WORDS-1:0] line_q;

  logic                    accept;
  logic                    beat;
  logic [IDXW-1:0]         start_word;
  logic [IDXW-1:0]         line_idx;
  logic                    unused_rid;

  assign unused_rid = ^rid_i;

  assign accept     = (state_q == IDLE) && fetch_req_i && !flush_i &&
                      (fetch_addr_i[1:0] == 2'b00);
  assign beat       = (state_q == R) && rvalid_i;
  assign start_word = addr_q[IDXW+1:2];
  // Wrap-around of the line index falls out of the IDXW-bit addition.
  assign line_idx   = start_word + beat_q[IDXW-1:0];

  always_comb begin
    state_d        = state_q;
    stall_req_o    = 1'b0;
    arvalid_o      = 1'b0;
    arid_o         = '0;
    araddr_o       = '0;
    arlen_o        = '0;
    arsize_o       = '0;
    arburst_o      = '0;
    rready_o       = 1'b0;
    inst_valid_o   = 1'b0;
    refill_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall_req_o = 1'b1;
          state_d     = AR;
        end
      end
      AR: begin
        stall_req_o = 1'b1;
        arvalid_o   = 1'b1;
        arid_o      = AXI_ID;
        araddr_o    = addr_q;
        arsize_o    = 3'b010;
        arlen_o     = cached_q ? 8'(LINE_WORDS - 1) : 8'd0;
        arburst_o   = cached_q ? 2'b10 : 2'b01;
        if (arready_i) state_d = R;
      end
      R: begin
        stall_req_o = 1'b1;
        rready_o    = 1'b1;
        if (rvalid_i && rlast_i) state_d = RESP;
      end
      RESP: begin
        inst_valid_o   = !cancel_q && !flush_i;
        refill_valid_o = !cancel_q && !flush_i && cached_q && !err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cached_q      <= 1'b0;
      cancel_q      <= 1'b0;
      err_q         <= 1'b0;
      beat_q        <= '0;
      inst_q        <= '0;
      refill_addr_q <= '0;
      line_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= fetch_addr_i;
        cached_q <= fetch_cached_i;
        cancel_q <= 1'b0;
        err_q    <= 1'b0;
        beat_q   <= '0;
      end else begin
        if (flush_i && (state_q != IDLE)) cancel_q <= 1'b1;
        if (beat) begin
          if (beat_q == 8'd0) inst_q <= rdata_i;
          if (cached_q) line_q[{line_idx, 5'b00000} +: 32] <= rdata_i;
          if (rresp_i != 2'b00) err_q <= 1'b1;
          beat_q <= beat_q + 8'd1;
          if (rlast_i && cached_q)
            refill_addr_q <= {addr_q[31:IDXW+2], {(IDXW+2){1'b0}}};
        end
      end
    end
  end

  assign inst_rdata_o  = inst_q;
  assign bus_error_o   = err_q;
  assign refill_addr_o = refill_addr_q;
  assign refill_data_o = line_q;

endmodule

// File: tb/tb_inst_axi_reader.sv
// Directed bench for inst_axi_reader: a zero/low-wait AXI slave driven step by step,
// with expected fetch results queued at request time and checked when the pulse appears.
module tb_inst_axi_reader;

  localparam int LW = 4;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              fetch_req_i, fetch_cached_i, flush_i;
  logic [31:0]       fetch_addr_i;
  logic              stall_req_o, inst_valid_o, bus_error_o, refill_valid_o;
  logic [31:0]       inst_rdata_o, refill_addr_o, araddr_o, rdata_i;
  logic [32*LW-1:0]  refill_data_o;
  logic [3:0]        arid_o, rid_i;
  logic [7:0]        arlen_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o, rresp_i;
  logic              arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

  always #5 clock_i = ~clock_i;

  inst_axi_reader #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_cached_i(fetch_cached_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .inst_valid_o(inst_valid_o),
    .inst_rdata_o(inst_rdata_o), .bus_error_o(bus_error_o),
    .refill_valid_o(refill_valid_o), .refill_addr_o(refill_addr_o),
    .refill_data_o(refill_data_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o),
    .arready_i(arready_i), .rid_i(rid_i), .rdata_i(rdata_i),
    .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o)
  );

  typedef struct {
    logic [31:0]      inst;
    logic             err;
    logic             refill;
    logic [31:0]      raddr;
    logic [32*LW-1:0] line;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total = 0, passed = 0, failed = 0;
  int   pulses = 0, pushed = 0;
  int   cyc_cnt = 0;

  always @(posedge clock_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  // Scoreboard consumer: every delivered instruction must match the oldest queued fetch.
  always @(negedge clock_i) begin
    if (reset_i && inst_valid_o) begin
      pulses = pulses + 1;
      chk("pulse_expected", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk("inst_rdata", inst_rdata_o, got.inst);
        chk("bus_error", bus_error_o, got.err);
        chk("refill_valid", refill_valid_o, got.refill);
        chk("latency", cyc_cnt, got.cyc);
        if (got.refill) begin
          chk("refill_addr", refill_addr_o, got.raddr);
          chk("refill_data", refill_data_o, got.line);
        end
      end
    end
    if (reset_i && refill_valid_o) chk("refill_implies_inst", inst_valid_o, 1'b1);
  end

  task automatic fetch(input logic [31:0] a, input logic c, input logic [31:0] base,
                       input int ar_wait, input int flush_beat, input int err_beat);
    int          n;
    int          start;
    logic        err;
    logic [31:0] d[LW];
    exp_t        e;
    n     = c ? LW : 1;
    start = c ? int'((a >> 2) % LW) : 0;
    err   = 1'b0;
    for (int i = 0; i < LW; i++) d[i] = base + 32'(i) * 32'h1111_1111;
    for (int i = 0; i < n; i++) if (i == err_beat) err = 1'b1;
    e.inst   = d[0];
    e.err    = err;
    e.refill = c && !err;
    e.raddr  = a & ~32'(LW * 4 - 1);
    e.line   = '0;
    for (int i = 0; i < n; i++) e.line[((start + i) % LW) * 32 +: 32] = d[i];

    fetch_req_i    = 1'b1;
    fetch_addr_i   = a;
    fetch_cached_i = c;
    e.cyc = cyc_cnt + 2 + ar_wait + n;
    if (flush_beat < 0) begin
      sb.push_back(e);
      pushed = pushed + 1;
    end
    #2;
    chk("stall_accept", stall_req_o, 1'b1);
    cyc();
    fetch_req_i  = 1'b0;
    fetch_addr_i = 32'hDEAD_BEE0;
    for (int w = 0; w <= ar_wait; w++) begin
      arready_i = (w == ar_wait);
      #2;
      chk("ar_fields",
          {arvalid_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, rready_o, stall_req_o},
          {1'b1, 4'd0, a, (c ? 8'(LW - 1) : 8'd0), 3'b010, (c ? 2'b10 : 2'b01), 1'b0, 1'b1});
      cyc();
    end
    arready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      rvalid_i = 1'b1;
      rdata_i  = d[i];
      rresp_i  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast_i  = (i == n - 1);
      flush_i  = (i == flush_beat);
      #2;
      chk("r_phase", {rready_o, stall_req_o, arvalid_o}, 3'b110);
      cyc();
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    flush_i  = 1'b0;
    #2;
    chk("resp_stall", stall_req_o, 1'b0);
    if (flush_beat >= 0) chk("cancel_no_pulse", {inst_valid_o, refill_valid_o}, 2'b00);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_req_i = 0; fetch_addr_i = '0; fetch_cached_i = 0; flush_i = 0;
    arready_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0; rvalid_i = 0;
    reset_i = 1'b1;
    #1 reset_i = 1'b0;
    #2;
    chk("reset_ctrl", {stall_req_o, inst_valid_o, bus_error_o, refill_valid_o, arvalid_o,
                       rready_o, arid_o, arlen_o, arsize_o, arburst_o}, '0);
    chk("reset_data", {inst_rdata_o, refill_addr_o, araddr_o}, '0);
    chk("reset_line", refill_data_o, '0);
    cyc(); cyc();
    reset_i = 1'b1;
    cyc();

    fetch(32'hBFC0_0000, 1'b0, 32'h3C08_0001, 0, -1, -1);
    fetch(32'h8000_0008, 1'b1, 32'h0D2D_2D2D, 0, -1, -1);
    fetch(32'h8000_0014, 1'b1, 32'h1234_5678, 5, -1, -1);
    fetch(32'h9000_0100, 1'b0, 32'hCAFE_0000, 5, -1, -1);
    fetch(32'h8000_0020, 1'b1, 32'hA000_0001, 0, 1, -1);
    fetch(32'hBFC0_0004, 1'b0, 32'h2402_0007, 0, -1, -1);
    fetch(32'h8000_003C, 1'b1, 32'h5555_0000, 0, -1, 2);
    fetch(32'h8000_0040, 1'b1, 32'h7777_0000, 1, 3, -1);
    fetch(32'h8000_004C, 1'b1, 32'h0BAD_F00D, 0, -1, -1);

    // Flush in IDLE blocks acceptance.
    fetch_req_i = 1'b1; fetch_addr_i = 32'hBFC0_0010; fetch_cached_i = 1'b0; flush_i = 1'b1;
    #2;
    chk("idle_flush_stall", stall_req_o, 1'b0);
    cyc();
    fetch_req_i = 1'b0; flush_i = 1'b0;
    #2;
    chk("idle_flush_no_ar", arvalid_o, 1'b0);
    cyc();

    // Misaligned request is dropped.
    fetch_req_i = 1'b1; fetch_addr_i = 32'hBFC0_0002;
    #2;
    chk("misaligned_stall", stall_req_o, 1'b0);
    cyc();
    fetch_req_i = 1'b0;
    #2;
    chk("misaligned_no_ar", arvalid_o, 1'b0);
    cyc();

    // Asynchronous reset in the middle of a cached burst.
    fetch_req_i = 1'b1; fetch_addr_i = 32'h8000_0004; fetch_cached_i = 1'b1;
    cyc();
    fetch_req_i = 1'b0; arready_i = 1'b1;
    cyc();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hFEED_0001; rlast_i = 1'b0;
    cyc();
    rdata_i = 32'hFEED_0002;
    #1;
    chk("pre_reset_rready", {rready_o, stall_req_o}, 2'b11);
    reset_i = 1'b0;
    #1;
    chk("midreset_ctrl", {stall_req_o, inst_valid_o, bus_error_o, refill_valid_o, arvalid_o,
                          rready_o, arlen_o, arburst_o}, '0);
    chk("midreset_data", {inst_rdata_o, refill_addr_o, araddr_o}, '0);
    chk("midreset_line", refill_data_o, '0);
    rvalid_i = 1'b0;
    cyc();
    reset_i = 1'b1;
    cyc();
    fetch(32'hBFC0_0000, 1'b0, 32'h3C08_0001, 0, -1, -1);
    cyc(); cyc();

    chk("pulse_count", pulses, pushed);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_axi_reader.md
Name: inst_axi_reader

Overview:
- Responder side of the instruction-fetch request interface driven by the PC stage. Takes fetch_req_i, fetch_addr_i and fetch_cached_i, and runs the AXI4 read transaction.
- Returns the instruction word and, for cacheable requests, a full refill line for the I-cache.
- Asserts stall_req_o to hold the PC stage while a fetch is outstanding.
- Sits between the PC/IF stage and the AXI crossbar read channel.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, 2..16; cacheable burst length.
- AXI_ID, 4'd0, constant ARID driven on all requests.

Ports:
- clock_i  input  1  system clock; all state changes on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- fetch_req_i  input  1  fetch request from PC stage; sampled only in IDLE.
- fetch_addr_i  input  32  fetch byte address.
- fetch_cached_i  input  1  1 = cacheable (line burst); 0 = uncached (single beat).
- flush_i  input  1  exception/redirect; cancels the outstanding fetch result.
- stall_req_o  output  1  hold PC stage.
- inst_valid_o  output  1  one-cycle pulse: inst_rdata_o/bus_error_o valid.
- inst_rdata_o  output  32  requested instruction word.
- bus_error_o  output  1  any beat of this transaction had RRESP != OKAY.
- refill_valid_o  output  1  one-cycle pulse: refill line valid.
- refill_addr_o  output  32  line-aligned address of the refill line.
- refill_data_o  output  32*LINE_WORDS  refill line; word i at bits [32i+31:32i].
- arid_o  output  4  read address ID.
- araddr_o  output  32  read address.
- arlen_o  output  8  burst length minus one.
- arsize_o  output  3  beat size.
- arburst_o  output  2  burst type.
- arvalid_o  output  1  read address valid.
- arready_i  input  1  read address ready.
- rid_i  input  4  read data ID; ignored.
- rdata_i  input  32  read data.
- rresp_i  input  2  read response.
- rlast_i  input  1  last beat of burst.
- rvalid_i  input  1  read data valid.
- rready_o  output  1  read data ready.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - FSM to IDLE.
  - All outputs 0, including arvalid_o, rready_o, inst_valid_o, refill_valid_o, stall_req_o, data and address registers.
  - Reset mid-burst abandons the transaction; the interconnect is reset with it.
- FSM states: IDLE, AR, R, RESP.
- IDLE:
  - Accepts a request when fetch_req_i=1, flush_i=0 and fetch_addr_i[1:0]==0.
  - On accept: latch address and cached flag, clear cancel/error/beat count, go to AR.
  - Misaligned requests are dropped: no bus activity, no pulse. The address exception is reported upstream.
- AR:
  - arvalid_o=1; arid_o=AXI_ID; arsize_o=3'b010.
  - Uncached: araddr_o=latched address; arlen_o=0; arburst_o=2'b01 (INCR).
  - Cached: araddr_o=latched word address (critical word first); arlen_o=LINE_WORDS-1; arburst_o=2'b10 (WRAP).
  - AR fields stay stable until arready_i=1. The handshake cycle moves the FSM to R.
- R:
  - rready_o=1.
  - On each rvalid_i beat:
    - Beat 0 writes inst_rdata_o.
    - Cached: the beat is stored at line index (start_word + beat) mod LINE_WORDS, where start_word = addr[log2(LINE_WORDS)+1:2].
    - rresp_i != 2'b00 sets the error flag (sticky within the transaction).
    - Beat counter increments.
  - The beat with rlast_i=1 moves the FSM to RESP. rlast_i alone terminates the burst; beat-count mismatch is not checked.
- RESP (exactly one cycle):
  - If not cancelled: inst_valid_o=1; bus_error_o=error flag.
  - If cached, not cancelled and no error: refill_valid_o=1; refill_addr_o = address with low log2(LINE_WORDS)+2 bits zeroed.
  - Next state IDLE. A new request is accepted no earlier than the following cycle.
- stall_req_o is combinational: 1 in AR and R, and in IDLE in the cycle a request is accepted. It is 0 in RESP, so the pipeline advances with the returned word.
- Flush:
  - flush_i=1 in AR, R or RESP sets cancel.
  - The AXI transaction always completes: AR is held and all beats are drained. Aborting is illegal.
  - With cancel set, RESP produces no inst_valid_o and no refill_valid_o.
  - flush_i=1 in IDLE blocks acceptance that cycle.
  - Flush and rlast arriving in the same cycle: cancel wins.
- Latency (zero-wait slave, arready and first rvalid each in the earliest cycle):
  - Uncached: request accepted at cycle 0; inst_valid_o at cycle 3.
  - Cached: inst_valid_o at cycle 2+LINE_WORDS.
- Outputs hold their last values after a pulse.

Test Plan:
- Uncached fetch of 0xBFC00000; slave returns 0x3C080001 with OKAY, zero wait → arlen=0, arburst=01; inst_rdata_o=0x3C080001 with inst_valid_o at cycle 3; refill_valid_o stays 0; stall_req_o high cycles 0-2.
- Cached fetch of 0x80000008, LINE_WORDS=4; beats D2,D3,D0,D1 → araddr=0x80000008, arlen=3, arburst=10; inst_rdata_o=D2; refill_addr_o=0x80000000; refill_data_o words 0..3 = D0..D3.
- arready_i held low for 5 cycles → arvalid_o and all AR fields stable throughout; no rready_o until the handshake.
- flush_i pulsed during beat 1 of a cached burst → all 4 beats accepted; no inst_valid_o or refill_valid_o; FSM returns to IDLE and accepts the next request.
- Cached burst with rresp=2'b10 on beat 2 → inst_valid_o=1, bus_error_o=1, refill_valid_o=0.
- reset_i asserted low mid-burst → all outputs 0 immediately (asynchronous); after release, a fetch of 0xBFC00000 completes normally. A misaligned request 0xBFC00002 → no arvalid_o.
